// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the single-cycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int DATA_W      = 32;
   localparam int DRAM_ADDR_W = 7;
   localparam int DRAM_DEPTH  = 128;

   typedef logic [31:0] word_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// Module      : data_ram
// Description : Word-organised data memory. Reads are combinational, writes
//               are synchronous, and the flop array clears asynchronously.
//               Optional build macro DATA_RAM_PRELOAD_EN: reset loads word k
//               with the value k instead of 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::DRAM_ADDR_W,
   parameter int DEPTH  = mips_pkg::DRAM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              w_enable,
   output logic [DATA_W-1:0] o_data
);

   import mips_pkg::*;

   // DEPTH is expected to equal 2**ADDR_W so that every index hits a word.
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] w_idx;
   logic              w_unused_addr_bits;

   // Upper address bits alias onto the low words and are deliberately dropped.
   assign w_idx              = i_addr[ADDR_W-1:0];
   assign w_unused_addr_bits = ^i_addr[31:ADDR_W];

   function automatic logic [DATA_W-1:0] reset_word(input int k);
`ifdef DATA_RAM_PRELOAD_EN
      return DATA_W'(k);
`else
      return '0;
`endif
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= reset_word(k);
         end
      end else if (w_enable) begin
         r_mem[w_idx] <= i_data;
      end
   end

   assign o_data = r_mem[w_idx];

endmodule : data_ram

`default_nettype wire

// File: tb/tb_data_ram.sv
// ============================================================================
// Module      : tb_data_ram
// Description : Directed self-checking bench for data_ram with an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram;

`ifdef DATA_RAM_PRELOAD_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        w_enable;
   logic [31:0] o_data;

   int errors = 0;
   int checks = 0;
   bit started = 0;

   logic [31:0] model [128];

   data_ram dut (
      .clk      (clk),
      .rst      (rst),
      .i_addr   (i_addr),
      .i_data   (i_data),
      .w_enable (w_enable),
      .o_data   (o_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rv(input int k);
      return PRE ? 32'(k) : 32'd0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (addr %0d)", name, act, exp, i_addr);
      end
   endtask

   // Memory model: a plain array, cleared on reset, written when enabled.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 128; k++) model[k] = rv(k);
      end else if (w_enable) begin
         model[i_addr % 128] = i_data;
      end
   end

   always @(negedge clk) begin
      if (started) check("cycle_read", o_data, model[i_addr % 128]);
   end

   initial begin
      rst      = 1'b1;
      i_addr   = 32'd0;
      i_data   = 32'd0;
      w_enable = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      started = 1;

      // Reset contents
      i_addr = 32'd0;  #1 check("rst_addr0",  o_data, 32'd0);
      i_addr = 32'd1;  #1 check("rst_addr1",  o_data, PRE ? 32'd1  : 32'd0);
      i_addr = 32'd2;  #1 check("rst_addr2",  o_data, PRE ? 32'd2  : 32'd0);
      i_addr = 32'd53; #1 check("rst_addr53", o_data, PRE ? 32'd53 : 32'd0);

      // Write then read; neighbours untouched
      i_data = 32'd127; w_enable = 1'b1;
      @(posedge clk); #2 w_enable = 1'b0;
      #1 check("wr_addr53", o_data, 32'd127);
      i_addr = 32'd52; #1 check("nb_addr52", o_data, PRE ? 32'd52 : 32'd0);
      i_addr = 32'd54; #1 check("nb_addr54", o_data, PRE ? 32'd54 : 32'd0);

      // Write-disable hold
      i_addr = 32'd53; i_data = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #2 check("hold_addr53", o_data, 32'd127);

      // Read-during-write: old value before the edge, new after
      w_enable = 1'b1;
      #1 check("rdw_before", o_data, 32'd127);
      @(posedge clk); #1 check("rdw_after", o_data, 32'hDEADBEEF);
      #1 w_enable = 1'b0;

      // Aliasing: 133 maps to word 5
      i_addr = 32'd133; i_data = 32'h5A5A5A5A; w_enable = 1'b1;
      @(posedge clk); #2 w_enable = 1'b0;
      i_addr = 32'd5;   #1 check("alias_addr5", o_data, 32'h5A5A5A5A);
      i_addr = 32'd261; #1 check("alias_addr261", o_data, 32'h5A5A5A5A);

      // Async reset mid-operation
      i_addr = 32'd10; i_data = 32'h1234; w_enable = 1'b1;
      @(posedge clk); #2 check("fill_addr10", o_data, 32'h1234);
      i_data = 32'hFFFF;
      #1 rst = 1'b1;
      #1 check("rst_async_drop", o_data, PRE ? 32'd10 : 32'd0);
      @(posedge clk); #2 check("rst_edge_nowrite", o_data, PRE ? 32'd10 : 32'd0);
      w_enable = 1'b0;
      #1 rst = 1'b0;
      #1 check("rst_release10", o_data, PRE ? 32'd10 : 32'd0);
      i_addr = 32'd53; #1 check("rst_clear53", o_data, PRE ? 32'd53 : 32'd0);
      i_addr = 32'd5;  #1 check("rst_clear5",  o_data, PRE ? 32'd5  : 32'd0);

      // Writes resume after reset
      i_addr = 32'd10; i_data = 32'h77; w_enable = 1'b1;
      @(posedge clk); #2 w_enable = 1'b0;
      #1 check("post_rst_write", o_data, 32'h77);
      repeat (2) @(posedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_data_ram

`default_nettype wire
